call_scheduler: RTL
===================

Name: call_scheduler

Overview:
- Upstream stage of the elevator controller; sits between the raw floor-call buttons and the movement block.
- Debounces the three call buttons and latches pending calls, which drive the green call LEDs.
- Clears each call when that floor is served.
- Runs a SCAN-style direction state machine that presents one registered target floor and a travel direction to movement.
- An active sos_mode from the emergency block flushes the scheduler and holds it idle.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive high samples required before a button press is accepted. Legal range 1..255.

Ports:
- clk  input  1  system clock (divided elevator clock).
- reset_n  input  1  asynchronous, active-low reset.
- button1  input  1  raw call button, floor 1, active-high.
- button2  input  1  raw call button, floor 2, active-high.
- button3  input  1  raw call button, floor 3, active-high.
- floor1  input  1  cabin at floor 1 (one-hot position from movement).
- floor2  input  1  cabin at floor 2.
- floor3  input  1  cabin at floor 3.
- door  input  1  door open (from movement).
- sos_mode  input  1  emergency active (from emergency).
- led1  output  1  call pending, floor 1.
- led2  output  1  call pending, floor 2.
- led3  output  1  call pending, floor 3.
- target_floor  output  2  target floor: 1, 2 or 3; 0 means none.
- dir_up  output  1  travel upward.
- dir_down  output  1  travel downward.
- call_valid  output  1  target_floor is meaningful.

Behaviour:

Reset (reset_n low, asynchronous):
- All outputs 0.
- Debounce counters 0; armed flags 1.
- Position register = 1; FSM = IDLE.
- Reset taken mid-operation discards all pending calls.

Debounce (per button, independent):
- Counter increments while the button is high, saturating at DEBOUNCE_CYCLES. Any low sample clears it to 0 and re-arms the button.
- A press is accepted in the cycle the counter reaches DEBOUNCE_CYCLES while the button is armed. That acceptance disarms the button.
- One held press yields exactly one accept. Re-triggering requires at least one low sample.

Position register:
- Loads from floor1..3 only when exactly one of them is high. Otherwise it holds its previous value.

Pending calls (pend[3:1], driving led1..3):
- Set: on accept for floor i, unless position == i and door is high in that cycle. In that case the press is ignored because the floor is already served.
- Clear: bit i clears when position == i and door is high.
- Set and clear for the same bit in the same cycle: clear wins.
- Latency: press accepted in cycle N, led visible after edge N+1.

Direction FSM (states IDLE, UP, DOWN; registered outputs):
- Definitions: above = any pend bit > position; below = any pend bit < position; here = pend[position].
- IDLE:
  - If here and door is low: target = position, call_valid = 1, no direction. The movement block reopens the door.
  - Else if above: go to UP.
  - Else if below: go to DOWN.
  - Otherwise remain in IDLE.
  - When both above and below are pending from IDLE, UP wins.
- UP:
  - target = nearest pending floor above position; dir_up = 1.
  - If none above and below exists: go to DOWN.
  - If none at all: go to IDLE.
- DOWN: mirror of UP.
- A new call behind the travel direction is deferred until no calls remain ahead (no reversal).
- Transitions take one cycle. Outputs reflect the new state after the next edge. Accept at N gives target_floor at edge N+2.
- Outputs when call_valid = 0: target_floor = 0 and dir_up = dir_down = 0.
- dir_up and dir_down are never both high.

Emergency (sos_mode high):
- pend is cleared, accepts are discarded, FSM is forced to IDLE, and all outputs are 0.
- Debounce counters keep running, so a button held through SOS release does not produce a fresh accept unless it is re-pressed.

Boundaries:
- At floor 3, "above" is always false; at floor 1, "below" is always false.
- Simultaneous accepts on several buttons are all latched in the same cycle.

Test Plan:
- DEBOUNCE_CYCLES=3. Glitch: button2 high for 2 cycles, then low -> led2 stays 0. Held for 10 cycles -> led2 = 1 exactly once; no second accept until a low sample.
- Position 1, idle. Press button3 -> led3 = 1 at N+1; target_floor = 3, dir_up = 1, call_valid = 1 at N+2. Then floor3 and door high -> led3 clears next edge; FSM returns to IDLE and all outputs go to 0.
- Position 2, FSM UP toward 3. Press button1 while the floor-3 call is pending -> target remains 3. After 3 is served -> DOWN, target_floor = 1, dir_down = 1.
- Position 2, idle. button1 and button3 accepted in the same cycle -> UP wins: target_floor = 3, then 1.
- Position 2 with door high. Press button2 -> led2 never sets. With door low, press button2 -> target_floor = 2, call_valid = 1, dir_up = dir_down = 0.
- Pending calls 1 and 3, then sos_mode = 1 -> leds and outputs go to 0 next edge; presses during SOS are ignored. Separately, reset_n low mid-travel -> outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/call_scheduler.sv
// Call scheduler: debounces the three floor-call buttons, latches pending
// calls (LEDs), tracks cabin position and runs a SCAN direction FSM that
// presents one registered target floor and direction to the movement block.
//
// state  | meaning
// IDLE   | no travel direction; may present the current floor if it is called
// UP     | serving calls above the cabin, nearest first
// DOWN   | serving calls below the cabin, nearest first
module call_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       door,
  input  logic       sos_mode,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] target_floor,
  output logic       dir_up,
  output logic       dir_down,
  output logic       call_valid
);

  localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  logic [3:1]      btn;
  logic [3:1][7:0] cnt_q, cnt_d, cnt_inc;
  logic [3:1]      armed_q, armed_d;
  logic [3:1]      accept;
  logic [3:1]      pend_q, pend_d;
  logic [3:1]      served;
  logic [1:0]      pos_q, pos_d;
  state_t          state_q, state_d;
  logic [1:0]      tgt_q, tgt_d;
  logic            up_q, up_d, dn_q, dn_d, vld_q, vld_d;
  logic            above, below, here;
  logic [1:0]      near_up, near_dn;

  assign btn = {button3, button2, button1};

  // Per-button saturating debounce; accept once per press while armed.
  // Accepts are still consumed during SOS so a held button cannot fire on release.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_inc = cnt_q;
    armed_d = armed_q;
    accept  = '0;
    for (int i = 1; i <= 3; i++) begin
      cnt_inc[i] = (cnt_q[i] == DB_MAX) ? cnt_q[i] : cnt_q[i] + 8'd1;
      if (btn[i]) begin
        cnt_d[i] = cnt_inc[i];
        if (armed_q[i] && (cnt_inc[i] == DB_MAX)) begin
          accept[i]  = 1'b1;
          armed_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]   = 8'd0;
        armed_d[i] = 1'b1;
      end
    end
  end

  // Position follows the one-hot floor sensors only when exactly one is high.
  always_comb begin
    pos_d = pos_q;
    case ({floor3, floor2, floor1})
      3'b001:  pos_d = 2'd1;
      3'b010:  pos_d = 2'd2;
      3'b100:  pos_d = 2'd3;
      default: pos_d = pos_q;
    endcase
  end

  // Pending calls: set on accept, cleared when the floor is served (clear wins).
  always_comb begin
    pend_d = pend_q;
    served = '0;
    for (int i = 1; i <= 3; i++) begin
      served[i] = door && (pos_q == i[1:0]);
      pend_d[i] = (pend_q[i] | accept[i]) & ~served[i];
    end
    if (sos_mode) pend_d = '0;
  end

  // Call geometry relative to the current position.
  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    here    = 1'b0;
    near_up = 2'd3;
    near_dn = 2'd1;
    case (pos_q)
      2'd1: begin
        above   = pend_q[2] | pend_q[3];
        here    = pend_q[1];
        near_up = pend_q[2] ? 2'd2 : 2'd3;
      end
      2'd2: begin
        above = pend_q[3];
        below = pend_q[1];
        here  = pend_q[2];
      end
      2'd3: begin
        below   = pend_q[1] | pend_q[2];
        here    = pend_q[3];
        near_dn = pend_q[2] ? 2'd2 : 2'd1;
      end
      default: ;
    endcase
  end

  // Direction FSM next state and registered outputs; no reversal while calls remain ahead.
  always_comb begin
    state_d = state_q;
    tgt_d   = 2'd0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (here && !door) begin
          tgt_d = pos_q;
          vld_d = 1'b1;
        end else if (above) begin
          state_d = S_UP;
        end else if (below) begin
          state_d = S_DOWN;
        end
      end
      S_UP: begin
        if (!above) state_d = below ? S_DOWN : S_IDLE;
      end
      S_DOWN: begin
        if (!below) state_d = above ? S_UP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_UP) begin
      tgt_d = near_up;
      up_d  = 1'b1;
      vld_d = 1'b1;
    end else if (state_d == S_DOWN) begin
      tgt_d = near_dn;
      dn_d  = 1'b1;
      vld_d = 1'b1;
    end
    if (sos_mode) begin
      state_d = S_IDLE;
      tgt_d   = 2'd0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      vld_d   = 1'b0;
    end
  end

  // State, call and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= '1;
      pend_q  <= '0;
      pos_q   <= 2'd1;
      state_q <= S_IDLE;
      tgt_q   <= 2'd0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      pos_q   <= pos_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      vld_q   <= vld_d;
    end
  end

  assign led1         = pend_q[1];
  assign led2         = pend_q[2];
  assign led3         = pend_q[3];
  assign target_floor = tgt_q;
  assign dir_up       = up_q;
  assign dir_down     = dn_q;
  assign call_valid   = vld_q;

endmodule
